synch_fifo_ctrl: RTL and testbench
==================================

Name: synch_fifo_ctrl

Overview:
- Single-clock FIFO controller sitting directly upstream of the team's dual-port sram in the synch_fifo path.
- Converts producer write requests and consumer read requests into sram write/read enables and pointers.
- Tracks occupancy and generates full/empty/almost flags, plus a read-data-valid strobe aligned to the sram's 1-cycle registered read.
- Write data bypasses the controller and goes straight to sram wrdata; clk drives both sram wrclk and rdclk.

Parameters:
- PTR, 4, address width of the sram; DEPTH must equal 2**PTR.
- DEPTH, 16, number of entries.
- AF_LVL, 2, almost_full asserts when free slots <= AF_LVL.
- AE_LVL, 2, almost_empty asserts when occupancy <= AE_LVL.

Ports:
- clk  input  1  system clock; also feeds sram wrclk/rdclk.
- rst_n  input  1  asynchronous active-low reset.
- wr_req  input  1  producer push request.
- rd_req  input  1  consumer pop request.
- sram_wren  output  1  sram write enable.
- sram_wrptr  output  PTR  sram write address.
- sram_rden  output  1  sram read enable.
- sram_rdptr  output  PTR  sram read address.
- rd_valid  output  1  sram rddata valid this cycle.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- almost_full  output  1  free slots <= AF_LVL.
- almost_empty  output  1  occupancy <= AE_LVL.
- fifo_cnt  output  PTR+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state is cleared on the rst_n falling edge, with no clock required.
- Reset values: wr_ptr=0, rd_ptr=0, fifo_cnt=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0.
- Pointers: internal wr_ptr and rd_ptr are PTR+1 bits; the MSB is the wrap bit. sram_wrptr and sram_rdptr are the low PTR bits. Pointers wrap naturally from DEPTH-1 to 0, toggling the MSB.
- Acceptance (combinational):
  - wr_acc = wr_req & ~full.
  - rd_acc = rd_req & ~empty.
  - sram_wren = wr_acc; sram_rden = rd_acc.
- Pointer update: on each clk edge, wr_ptr += wr_acc and rd_ptr += rd_acc.
- Count update: fifo_cnt +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags: registered and decoded from the next-state count, so they are valid in the cycle after the access.
  - full = (next_cnt == DEPTH).
  - empty = (next_cnt == 0).
  - almost_full = (DEPTH - next_cnt <= AF_LVL).
  - almost_empty = (next_cnt <= AE_LVL).
- Read latency: rd_valid is a register of rd_acc, so it is high exactly one cycle after sram_rden. This aligns it with sram rddata.
- Full with wr_req & rd_req: the read is accepted and the write is rejected. Count goes to DEPTH-1 and full deasserts next cycle.
- Empty with wr_req & rd_req: the write is accepted and the read is rejected. Count goes to 1, empty deasserts, and no rd_valid pulse is issued.
- Not full/not empty with both requests: both are accepted and the count holds. The sram sees different addresses, except when count==0, which cannot occur here because a read requires ~empty.
- Rejected requests: dropped silently; the producer/consumer must hold or retry.
- Reset mid-operation: contents in the sram are abandoned. Pointers return to 0, and any rd_valid pending for the next cycle is cleared.

Optional Feature:
- Macro: SYNCH_FIFO_ERR_FLAG_EN.
- When defined, two outputs are added:
  - overflow: sticky, set when wr_req & full.
  - underflow: sticky, set when rd_req & empty.
- Both are cleared only by rst_n, and both reset to 0.
- When undefined, these ports and their registers do not exist; rejected requests are dropped with no indication.

Decomposition:
- Shared package synch_fifo_pkg holds:
  - default PTR, DEPTH, AF_LVL, AE_LVL constants;
  - a clog2-style helper for deriving PTR from DEPTH.
- No sub-module is required. The top-level synch_fifo instantiates synch_fifo_ctrl alongside sram. The bench uses that pair as its DUT.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release -> empty=1, almost_empty=1, full=0, fifo_cnt=0, no sram_wren/sram_rden/rd_valid.
- Fill: 16 consecutive wr_req with data 0x00..0x0F.
  - sram_wrptr steps 0..15.
  - almost_full rises when fifo_cnt=14.
  - full=1 after the 16th write.
  - A 17th wr_req gives sram_wren=0 and fifo_cnt stays 16 (overflow=1 if SYNCH_FIFO_ERR_FLAG_EN).
- Drain: 16 rd_req.
  - rd_valid follows each sram_rden by exactly 1 cycle.
  - rddata = 0x00..0x0F in order.
  - empty=1 after the last read.
  - An extra rd_req gives sram_rden=0 and no rd_valid (underflow=1 if enabled).
- Simultaneous at boundaries:
  - When full, wr_req&rd_req -> only the read is accepted, fifo_cnt=15.
  - When empty, wr_req&rd_req -> only the write is accepted, fifo_cnt=1, no rd_valid.
  - At count 8, both -> fifo_cnt stays 8 and both pointers advance.
- Wrap-around: write 10, read 10, write 10 -> sram_wrptr wraps 15->0 at the 16th write, fifo_cnt=10, and data reads back in order across the wrap.
- Async reset mid-burst: assert rst_n low between clk edges at count 7 with a read in flight -> all flags and pointers return to reset values immediately, and rd_valid stays 0 next cycle.

Source files
------------

// File: rtl/synch_fifo_pkg.sv
// ---------------------------------------------------------------------------
// synch_fifo_pkg
// Shared constants for the synch_fifo path (controller + dual-port sram).
//   SF_DEPTH  : default number of FIFO entries
//   SF_PTR    : default sram address width, derived from SF_DEPTH
//   SF_AF_LVL : default almost_full threshold (free slots)
//   SF_AE_LVL : default almost_empty threshold (occupancy)
//   sf_clog2  : ceil(log2(n)) helper for deriving address widths
// ---------------------------------------------------------------------------
package synch_fifo_pkg;

  function automatic int sf_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int SF_DEPTH  = 16;
  localparam int SF_PTR    = sf_clog2(SF_DEPTH);
  localparam int SF_AF_LVL = 2;
  localparam int SF_AE_LVL = 2;

endpackage

// File: rtl/synch_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// synch_fifo_ctrl
// Single-clock FIFO controller driving a dual-port sram with a 1-cycle
// registered read. Write data goes straight to the sram; this block only
// produces enables, addresses, occupancy and status flags.
//
// Ports:
//   clk          in   system clock (also sram wrclk/rdclk)
//   rst_n        in   asynchronous active-low reset
//   wr_req       in   producer push request
//   rd_req       in   consumer pop request
//   sram_wren    out  sram write enable (accepted write)
//   sram_wrptr   out  sram write address [PTR-1:0]
//   sram_rden    out  sram read enable (accepted read)
//   sram_rdptr   out  sram read address [PTR-1:0]
//   rd_valid     out  sram rddata valid this cycle
//   full/empty   out  occupancy == DEPTH / == 0
//   almost_full  out  free slots <= AF_LVL
//   almost_empty out  occupancy <= AE_LVL
//   fifo_cnt     out  occupancy 0..DEPTH [PTR:0]
//   overflow     out  sticky: wr_req while full   (SYNCH_FIFO_ERR_FLAG_EN)
//   underflow    out  sticky: rd_req while empty  (SYNCH_FIFO_ERR_FLAG_EN)
//
// Build option: define SYNCH_FIFO_ERR_FLAG_EN to add overflow/underflow.
// DEPTH must equal 2**PTR so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module synch_fifo_ctrl
  import synch_fifo_pkg::*;
#(
  parameter int PTR    = SF_PTR,
  parameter int DEPTH  = SF_DEPTH,
  parameter int AF_LVL = SF_AF_LVL,
  parameter int AE_LVL = SF_AE_LVL
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_req,
  input  logic           rd_req,
  output logic           sram_wren,
  output logic [PTR-1:0] sram_wrptr,
  output logic           sram_rden,
  output logic [PTR-1:0] sram_rdptr,
  output logic           rd_valid,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic [PTR:0]   fifo_cnt
`ifdef SYNCH_FIFO_ERR_FLAG_EN
  ,
  output logic           overflow,
  output logic           underflow
`endif
);

  localparam logic [PTR:0] LP_DEPTH = DEPTH[PTR:0];
  localparam logic [PTR:0] LP_AF    = AF_LVL[PTR:0];
  localparam logic [PTR:0] LP_AE    = AE_LVL[PTR:0];
  localparam logic [PTR:0] LP_ONE   = {{PTR{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit above the sram address.
  logic [PTR:0] r_wr_ptr;
  logic [PTR:0] r_rd_ptr;
  logic [PTR:0] r_cnt;
  logic         r_full;
  logic         r_empty;
  logic         r_afull;
  logic         r_aempty;
  logic         r_rd_valid;

  logic         w_wr_acc;
  logic         w_rd_acc;
  logic [PTR:0] w_cnt_nxt;

  // Full/empty are registered, so a simultaneous request at a boundary
  // resolves in favour of the side that can legally proceed.
  assign w_wr_acc = wr_req & ~r_full;
  assign w_rd_acc = rd_req & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_cnt + LP_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_cnt - LP_ONE;
    end
  end

  // Flags decode the next-state count so they line up with fifo_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + {{PTR{1'b0}}, w_wr_acc};
      r_rd_ptr   <= r_rd_ptr + {{PTR{1'b0}}, w_rd_acc};
      r_cnt      <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == LP_DEPTH);
      r_empty    <= (w_cnt_nxt == '0);
      r_afull    <= ((LP_DEPTH - w_cnt_nxt) <= LP_AF);
      r_aempty   <= (w_cnt_nxt <= LP_AE);
      // Matches the sram's registered read: data appears one cycle later.
      r_rd_valid <= w_rd_acc;
    end
  end

`ifdef SYNCH_FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_req & r_full);
      r_underflow <= r_underflow | (rd_req & r_empty);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign sram_wren    = w_wr_acc;
  assign sram_rden    = w_rd_acc;
  assign sram_wrptr   = r_wr_ptr[PTR-1:0];
  assign sram_rdptr   = r_rd_ptr[PTR-1:0];
  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign fifo_cnt     = r_cnt;

endmodule

// File: tb/tb_synch_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_synch_fifo_ctrl
// Directed bench for synch_fifo_ctrl. A small behavioural sram with a
// 1-cycle registered read sits beside the controller so read data order
// can be checked. Inputs change on the falling edge; combinational outputs
// are sampled 1ns after that, registered outputs 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_synch_fifo_ctrl;

  localparam int PTR   = 4;
  localparam int DEPTH = 16;

  logic           clk;
  logic           rst_n;
  logic           wr_req;
  logic           rd_req;
  logic           sram_wren;
  logic [PTR-1:0] sram_wrptr;
  logic           sram_rden;
  logic [PTR-1:0] sram_rdptr;
  logic           rd_valid;
  logic           full;
  logic           empty;
  logic           almost_full;
  logic           almost_empty;
  logic [PTR:0]   fifo_cnt;
`ifdef SYNCH_FIFO_ERR_FLAG_EN
  logic           overflow;
  logic           underflow;
`endif

  logic [7:0] wdata;
  logic [7:0] rddata;
  logic [7:0] mem [DEPTH];

  int tests;
  int fails;

  synch_fifo_ctrl #(.PTR(PTR), .DEPTH(DEPTH), .AF_LVL(2), .AE_LVL(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .sram_wren    (sram_wren),
    .sram_wrptr   (sram_wrptr),
    .sram_rden    (sram_rden),
    .sram_rdptr   (sram_rdptr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_cnt     (fifo_cnt)
`ifdef SYNCH_FIFO_ERR_FLAG_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port sram, registered read.
  always @(posedge clk) begin
    if (sram_wren) mem[sram_wrptr] <= wdata;
    if (sram_rden) rddata <= mem[sram_rdptr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    wdata  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wdata  = 8'h00;

    // Reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_wren", sram_wren, 0);
    chk("rst_rden", sram_rden, 0);
    chk("rst_rdvld", rd_valid, 0);
`ifdef SYNCH_FIFO_ERR_FLAG_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
`endif

    // Fill 16 entries with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      chk("fill_wren", sram_wren, 1);
      chk("fill_wrptr", sram_wrptr, i);
      tick();
      chk("fill_cnt", fifo_cnt, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
      chk("fill_full", full, (i == 15) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end

    // 17th write is rejected
    drive(1'b1, 1'b0, 8'hEE);
    chk("ovf_wren", sram_wren, 0);
    tick();
    chk("ovf_cnt", fifo_cnt, 16);
    chk("ovf_full", full, 1);
`ifdef SYNCH_FIFO_ERR_FLAG_EN
    chk("ovf_flag", overflow, 1);
`endif

    // Full with both requests: only the read goes through
    drive(1'b1, 1'b1, 8'hEE);
    chk("fb_wren", sram_wren, 0);
    chk("fb_rden", sram_rden, 1);
    chk("fb_rdptr", sram_rdptr, 0);
    tick();
    chk("fb_cnt", fifo_cnt, 15);
    chk("fb_full", full, 0);
    chk("fb_rdvld", rd_valid, 1);
    chk("fb_data", rddata, 8'h00);

    // Drain the remaining 15 entries
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      chk("drn_rden", sram_rden, 1);
      chk("drn_rdptr", sram_rdptr, i);
      tick();
      chk("drn_rdvld", rd_valid, 1);
      chk("drn_data", rddata, i);
      chk("drn_cnt", fifo_cnt, 15 - i);
      chk("drn_empty", empty, (i == 15) ? 1 : 0);
    end

    // Extra read is rejected, no rd_valid pulse
    drive(1'b0, 1'b1, 8'h00);
    chk("udf_rden", sram_rden, 0);
    tick();
    chk("udf_rdvld", rd_valid, 0);
    chk("udf_cnt", fifo_cnt, 0);
`ifdef SYNCH_FIFO_ERR_FLAG_EN
    chk("udf_flag", underflow, 1);
`endif

    // Empty with both requests: only the write goes through (addr 0)
    drive(1'b1, 1'b1, 8'hA5);
    chk("eb_wren", sram_wren, 1);
    chk("eb_rden", sram_rden, 0);
    chk("eb_wrptr", sram_wrptr, 0);
    tick();
    chk("eb_cnt", fifo_cnt, 1);
    chk("eb_empty", empty, 0);
    chk("eb_rdvld", rd_valid, 0);

    // Bring count to 8 (addresses 1..7)
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i));
      tick();
    end
    chk("c8_cnt", fifo_cnt, 8);

    // Both requests at count 8
    drive(1'b1, 1'b1, 8'h55);
    chk("c8_wren", sram_wren, 1);
    chk("c8_rden", sram_rden, 1);
    chk("c8_wrptr", sram_wrptr, 8);
    chk("c8_rdptr", sram_rdptr, 0);
    tick();
    chk("c8_cnt_hold", fifo_cnt, 8);
    chk("c8_rdvld", rd_valid, 1);
    chk("c8_data", rddata, 8'hA5);
    drive(1'b0, 1'b0, 8'h00);
    chk("c8_wrptr_adv", sram_wrptr, 9);
    chk("c8_rdptr_adv", sram_rdptr, 1);

    // One read to reach count 7
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("c7_cnt", fifo_cnt, 7);
    chk("c7_data", rddata, 8'h10);

    // Async reset between edges with a read in flight
    drive(1'b0, 1'b1, 8'h00);
    chk("ar_rden_pre", sram_rden, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", fifo_cnt, 0);
    chk("ar_empty", empty, 1);
    chk("ar_aempty", almost_empty, 1);
    chk("ar_full", full, 0);
    chk("ar_afull", almost_full, 0);
    chk("ar_rdvld", rd_valid, 0);
    chk("ar_wrptr", sram_wrptr, 0);
    chk("ar_rdptr", sram_rdptr, 0);
    chk("ar_rden", sram_rden, 0);
    tick();
    chk("ar_rdvld_next", rd_valid, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    rd_req = 1'b0;

    // Wrap-around: write 10, read 10, write 10, read 10
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(8'h20 + i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      chk("wr1_data", rddata, 8'h20 + i);
    end
    chk("wr1_empty", empty, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i));
      chk("wrap_wrptr", sram_wrptr, (10 + i) % 16);
      tick();
    end
    chk("wrap_cnt", fifo_cnt, 10);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      chk("wrap_rdptr", sram_rdptr, (10 + i) % 16);
      tick();
      chk("wrap_data", rddata, 8'h40 + i);
    end
    chk("wrap_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
